pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three hazards: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory waits. A bounded memory-wait timeout latches a sticky error.

Parameters:
MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before entering ERR (range 1..255)
REG_W, 5, register-specifier width

Ports:
clk  input  1  pipeline clock, all state updates on posedge
rst  input  1  synchronous active-high reset
id_rs  input  REG_W  rs field of instruction in ID
id_rt  input  REG_W  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt
ex_mem_read  input  1  instruction in EX is a load
ex_reg_dst  input  REG_W  destination register of instruction in EX
ex_branch_taken  input  1  branch/jump in EX resolved taken
mem_req  input  1  instruction in MEM accesses data memory
mem_ready  input  1  data memory completes access this cycle
pc_write  output  1  PC load enable
ifid_write  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID clear to NOP (on next posedge)
idex_write  output  1  ID/EX load enable
idex_flush  output  1  ID/EX load bubble (ctrl=0)
exmem_write  output  1  EX/MEM load enable
mem_err  output  1  sticky memory-timeout error

Behaviour:
- State register: RUN, MEM_WAIT, ERR. Wait counter is 8 bits. Outputs are decoded combinationally from state and current inputs (Mealy).
- Reset (rst=1 at posedge): state=RUN, counter=0, mem_err=0. With rst held, outputs follow RUN decoding.
- freeze = (state==RUN && mem_req && !mem_ready) || (state==MEM_WAIT && !mem_ready) || state==ERR.
- While freeze=1:
  - pc_write=ifid_write=idex_write=exmem_write=0.
  - All flushes are 0.
  - Branch and load-use are not acted on. The branch stays in EX and is re-evaluated after release.
- load_use = ex_mem_read && ex_reg_dst!=0 && (ex_reg_dst==id_rs || (id_uses_rt && ex_reg_dst==id_rt)).
- Priority when not frozen: branch > load_use > normal.
  - Branch: pc_write=1, ifid_flush=1, idex_flush=1, all writes 1.
  - Load-use: pc_write=0, ifid_write=0, idex_flush=1, idex_write=1, exmem_write=1. Exactly one bubble per hazard; the next cycle the load is in MEM and the hazard clears.
  - Normal: all writes 1, flushes 0.
- Transitions:
  - RUN → MEM_WAIT when mem_req && !mem_ready; counter:=1.
  - MEM_WAIT with mem_ready: release in that same cycle (outputs as RUN, non-frozen), next state RUN, counter:=0.
  - MEM_WAIT with !mem_ready: counter++. When counter==MEM_TIMEOUT and still !mem_ready, next state is ERR and mem_err:=1.
  - ERR is absorbing until rst.
- mem_ready with mem_req=0 is ignored in RUN.
- Reset mid-wait aborts the wait: state RUN, counter 0.

Optional Feature:
Macro HAZARD_STATS_EN.
- When defined, adds outputs stall_cycles[31:0] and flush_count[31:0], both saturating at 0xFFFFFFFF and cleared by rst.
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_count increments on every cycle with ifid_flush=1.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds the state enum (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2), REG_W default, and the NOP control constant 4'b0000 used by the pipeline registers.
- One natural sub-module: hazard_detect, the combinational load_use compare instantiated inside pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_dst=8, id_rs=8 → same cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle (ex_mem_read=0) all writes 1.
- Load to $0: ex_reg_dst=0, id_rs=0, ex_mem_read=1 → no stall, all writes 1.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with a load-use match → pc_write=1, ifid_flush=1, idex_flush=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 → all writes 0 for 3 cycles, released on the 4th, state RUN after.
- Timeout with MEM_TIMEOUT=4: mem_ready held 0 → mem_err=1 after the 4th wait cycle, permanent freeze; rst=1 → mem_err=0, state RUN.
- Branch during freeze: ex_branch_taken=1 while mem_ready=0 → no flush; flush is asserted on the release cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared definitions for the pipeline hazard sequencer and the pipeline
// registers it controls.
//   hazard_state_e : sequencer state encoding (RUN, MEM_WAIT, ERR)
//   REG_W_DEFAULT  : default register-specifier width
//   NOP_CTRL       : control-field value a flushed pipeline register loads
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } hazard_state_e;

  localparam int REG_W_DEFAULT = 5;

  localparam logic [3:0] NOP_CTRL = 4'b0000;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect
// Combinational load-use compare between the load sitting in EX and the
// source operands of the instruction in ID.
// Ports:
//   id_rs, id_rt    : source register fields of the ID instruction
//   id_uses_rt      : ID instruction actually reads rt
//   ex_mem_read     : EX instruction is a load
//   ex_reg_dst      : destination register of the EX instruction
//   load_use        : ID must wait one cycle for the load result
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_reg_dst,
  output logic             load_use
);

  logic dst_nonzero;
  logic rs_match;
  logic rt_match;

  // Register $0 is hardwired to zero, so a load targeting it never
  // produces a value anyone has to wait for.
  always_comb begin
    dst_nonzero = (ex_reg_dst != '0);
    rs_match    = (ex_reg_dst == id_rs);
    rt_match    = id_uses_rt && (ex_reg_dst == id_rt);
    load_use    = ex_mem_read && dst_nonzero && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Drives the load
// enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers and
// resolves load-use hazards, taken branches in EX and data-memory waits.
// A memory wait longer than MEM_TIMEOUT cycles latches a sticky error.
// Optional feature macro: HAZARD_STATS_EN adds stall_cycles/flush_count.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt : ID instruction source operands
//   ex_mem_read, ex_reg_dst  : EX load info
//   ex_branch_taken          : branch/jump in EX resolved taken
//   mem_req, mem_ready       : data-memory handshake of the MEM instruction
//   pc_write .. exmem_write  : pipeline register enables and flushes
//   mem_err                  : sticky memory-timeout error
//   stall_cycles, flush_count: saturating statistics (HAZARD_STATS_EN only)
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int REG_W       = REG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_reg_dst,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             mem_err
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
`endif
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  hazard_state_e state, state_next, dec_state;
  logic [7:0]    wait_cnt, wait_cnt_next;
  logic          mem_err_next;
  logic          load_use;
  logic          freeze;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_reg_dst  (ex_reg_dst),
    .load_use    (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      mem_err  <= mem_err_next;
    end
  end

  // The RUN-state cycle that first sees the stall already counts as wait
  // cycle 1, so MEM_WAIT is occupied with counter values 1..MEM_TIMEOUT
  // before the error state is taken.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    mem_err_next  = mem_err;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_next    = RUN;
          wait_cnt_next = 8'd0;
        end else if (wait_cnt == TIMEOUT) begin
          state_next   = ERR;
          mem_err_next = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      ERR: begin
        state_next = ERR;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  // While reset is held the outputs decode as RUN, whatever the register
  // currently holds. A frozen pipeline ignores branches and load-use; the
  // branch stays in EX and is acted on in the release cycle.
  always_comb begin
    dec_state   = rst ? RUN : state;
    freeze      = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_write  = 1'b1;
    idex_flush  = 1'b0;
    exmem_write = 1'b1;
    case (dec_state)
      RUN:      freeze = mem_req && !mem_ready;
      MEM_WAIT: freeze = !mem_ready;
      default:  freeze = 1'b1;
    endcase
    if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_write && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (ifid_flush && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule
